// File: rtl/accel_pkg.sv
// Shared constants for the accelerometer reader: SPI command bytes, sensor
// register addresses, the measurement-mode value, FSM/shifter state encodings
// and the per-transaction MOSI byte tables.
package accel_pkg;

  // Sensor SPI commands
  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  // Sensor register addresses
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA     = 8'h08;

  // POWER_CTL value that turns measurement mode on
  localparam logic [7:0] POWER_CTL_MEASURE = 8'h02;

  // Transaction lengths in bytes
  localparam logic [2:0] INIT_NBYTES = 3'd3;
  localparam logic [2:0] READ_NBYTES = 3'd4;

  // Byte positions of the acceleration data inside a read transaction
  localparam logic [1:0] RD_IDX_X = 2'd2;
  localparam logic [1:0] RD_IDX_Y = 2'd3;

  // Reader FSM states
  typedef enum logic [2:0] {
    INIT      = 3'd0,
    INIT_XFER = 3'd1,
    WAIT      = 3'd2,
    READ_XFER = 3'd3,
    UPDATE    = 3'd4
  } state_t;

  // Shift-engine bit phases
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_SETUP = 3'd1,
    PH_LOW   = 3'd2,
    PH_HIGH  = 3'd3,
    PH_TAIL  = 3'd4
  } phase_t;

  // MOSI bytes of the measurement-mode write
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = CMD_WRITE;
      2'd1:    init_byte = REG_POWER_CTL;
      2'd2:    init_byte = POWER_CTL_MEASURE;
      default: init_byte = 8'h00;
    endcase
  endfunction

  // MOSI bytes of the X/Y data read (trailing bytes are dummies)
  function automatic logic [7:0] read_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    read_byte = CMD_READ;
      2'd1:    read_byte = REG_XDATA;
      default: read_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/accel_reader_spi.sv
// spi_shift_engine: byte-level SPI master, mode 0, MSB first.
// A transaction drops cs_n, waits CLK_DIV cycles, then shifts nbytes bytes
// (each bit = CLK_DIV cycles SCLK low + CLK_DIV cycles SCLK high), holds SCLK
// low for CLK_DIV more cycles and raises cs_n together with a done pulse.
// The next byte to send is requested through tx_idx and taken from tx_byte.
module spi_shift_engine
  import accel_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       start,
  input  logic [2:0] nbytes,
  input  logic [7:0] tx_byte,
  output logic [1:0] tx_idx,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic [1:0] rx_idx,
  output logic       done,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  phase_t     phase;
  logic [7:0] div_cnt;
  logic [2:0] bit_idx;
  logic [1:0] byte_idx;
  logic [2:0] nbytes_r;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;

  logic tick;
  logic bit_end;
  logic byte_end;
  logic last_byte;
  logic load_tx;
  logic shift_tx;
  logic sample_rx;

  // Phase timing and shift-register control strobes
  always_comb begin
    tick      = (div_cnt == DIV_LAST);
    bit_end   = (phase == PH_HIGH) && tick;
    byte_end  = bit_end && (bit_idx == 3'd7);
    last_byte = ({1'b0, byte_idx} == (nbytes_r - 3'd1));
    load_tx   = ((phase == PH_SETUP) && tick) || (byte_end && !last_byte);
    shift_tx  = bit_end && (bit_idx != 3'd7);
    sample_rx = (phase == PH_LOW) && tick;
    // While a bit is high the engine is about to start the following byte
    tx_idx    = (phase == PH_HIGH) ? byte_idx + 2'd1 : byte_idx;
    rx_byte   = rx_sh;
  end

  // Transaction sequencing, SCLK/MOSI/CS generation and status pulses
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase    <= PH_IDLE;
      div_cnt  <= 8'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      nbytes_r <= 3'd0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      rx_vld   <= 1'b0;
      rx_idx   <= 2'd0;
      done     <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      done   <= 1'b0;

      // MOSI only moves on entry to an SCLK-low phase
      if (load_tx) begin
        mosi <= tx_byte[7];
      end else if (shift_tx) begin
        mosi <= tx_sh[7];
      end else if (byte_end && last_byte) begin
        mosi <= 1'b0;
      end

      case (phase)
        PH_IDLE: begin
          if (start) begin
            cs_n     <= 1'b0;
            phase    <= PH_SETUP;
            div_cnt  <= 8'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            nbytes_r <= nbytes;
          end
        end
        PH_SETUP: begin
          if (tick) begin
            div_cnt <= 8'd0;
            phase   <= PH_LOW;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        PH_LOW: begin
          if (tick) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b1;
            phase   <= PH_HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        PH_HIGH: begin
          if (tick) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              rx_vld  <= 1'b1;
              rx_idx  <= byte_idx;
              if (last_byte) begin
                phase <= PH_TAIL;
              end else begin
                byte_idx <= byte_idx + 2'd1;
                phase    <= PH_LOW;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              phase   <= PH_LOW;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        PH_TAIL: begin
          if (tick) begin
            div_cnt <= 8'd0;
            cs_n    <= 1'b1;
            done    <= 1'b1;
            phase   <= PH_IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          phase <= PH_IDLE;
        end
      endcase
    end
  end

  // Data shift registers: TX shifts out MSB first, RX samples MISO as SCLK rises
  always_ff @(posedge clk) begin
    if (load_tx) begin
      tx_sh <= {tx_byte[6:0], 1'b0};
    end else if (shift_tx) begin
      tx_sh <= {tx_sh[6:0], 1'b0};
    end
    if (sample_rx) begin
      rx_sh <= {rx_sh[6:0], miso};
    end
  end

endmodule

// File: rtl/accel_reader.sv
// accel_reader: puts the SPI accelerometer into measurement mode after reset,
// then polls the X/Y data registers every POLL_PERIOD clocks and presents the
// signed samples to the ball physics stage with a one-cycle o_valid strobe.
// Optional feature macro: ACCEL_FILTER_EN -- when defined, each new output is
// the average of the previous output and the new sample (arithmetic shift,
// rounding toward minus infinity); otherwise raw samples are output.
module accel_reader
  import accel_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int POLL_PERIOD = 1048576
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_spi_miso,
  output logic              o_spi_sclk,
  output logic              o_spi_mosi,
  output logic              o_spi_cs_n,
  output logic signed [7:0] o_accel_x,
  output logic signed [7:0] o_accel_y,
  output logic              o_valid
);

  localparam int              TMR_W    = $clog2(POLL_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_PERIOD - 1);

`ifdef ACCEL_FILTER_EN
  // Two-tap average in 9-bit signed arithmetic, floor rounding
  function automatic logic signed [7:0] filt_avg(input logic signed [7:0] prev,
                                                 input logic signed [7:0] samp);
    logic signed [8:0] sum;
    sum      = $signed({prev[7], prev}) + $signed({samp[7], samp});
    sum      = sum >>> 1;
    filt_avg = sum[7:0];
  endfunction
`endif

  state_t            state;
  state_t            state_nxt;
  logic [TMR_W-1:0]  poll_tmr;
  logic              poll_hit;
  logic              eng_start;
  logic [2:0]        eng_nbytes;
  logic [7:0]        eng_tx_byte;
  logic [1:0]        eng_tx_idx;
  logic [7:0]        eng_rx_byte;
  logic              eng_rx_vld;
  logic [1:0]        eng_rx_idx;
  logic              eng_done;
  logic              read_txn;
  logic              upd;
  logic signed [7:0] shadow_x;
  logic signed [7:0] shadow_y;
  logic signed [7:0] next_x;
  logic signed [7:0] next_y;

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk     (clk),
    .arst_n  (arst_n),
    .start   (eng_start),
    .nbytes  (eng_nbytes),
    .tx_byte (eng_tx_byte),
    .tx_idx  (eng_tx_idx),
    .rx_byte (eng_rx_byte),
    .rx_vld  (eng_rx_vld),
    .rx_idx  (eng_rx_idx),
    .done    (eng_done),
    .miso    (i_spi_miso),
    .sclk    (o_spi_sclk),
    .mosi    (o_spi_mosi),
    .cs_n    (o_spi_cs_n)
  );

  // Next-state logic and transaction launch
  always_comb begin
    state_nxt  = state;
    eng_start  = 1'b0;
    eng_nbytes = INIT_NBYTES;
    case (state)
      INIT: begin
        eng_start  = 1'b1;
        eng_nbytes = INIT_NBYTES;
        state_nxt  = INIT_XFER;
      end
      INIT_XFER: begin
        if (eng_done) state_nxt = WAIT;
      end
      WAIT: begin
        if (poll_hit) begin
          eng_start  = 1'b1;
          eng_nbytes = READ_NBYTES;
          state_nxt  = READ_XFER;
        end
      end
      READ_XFER: begin
        if (eng_done) state_nxt = UPDATE;
      end
      UPDATE: begin
        state_nxt = WAIT;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // MOSI byte source, output update strobe and the next output values
  always_comb begin
    poll_hit    = (poll_tmr == TMR_LAST);
    read_txn    = (state == WAIT) || (state == READ_XFER);
    eng_tx_byte = read_txn ? read_byte(eng_tx_idx) : init_byte(eng_tx_idx);
    upd         = (state == READ_XFER) && eng_done;
`ifdef ACCEL_FILTER_EN
    next_x      = filt_avg(o_accel_x, shadow_x);
    next_y      = filt_avg(o_accel_y, shadow_y);
`else
    next_x      = shadow_x;
    next_y      = shadow_y;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Poll timer: cleared after the init write and at every read cs_n fall
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      poll_tmr <= '0;
    end else if (((state == INIT_XFER) && eng_done) || ((state == WAIT) && poll_hit)) begin
      poll_tmr <= '0;
    end else if (!poll_hit) begin
      poll_tmr <= poll_tmr + 1'b1;
    end
  end

  // Shadow capture of the X and Y data bytes of a read
  always_ff @(posedge clk) begin
    if ((state == READ_XFER) && eng_rx_vld) begin
      if (eng_rx_idx == RD_IDX_X) shadow_x <= eng_rx_byte;
      if (eng_rx_idx == RD_IDX_Y) shadow_y <= eng_rx_byte;
    end
  end

  // Outputs load together on entry to UPDATE; o_valid is high during UPDATE
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_accel_x <= '0;
      o_accel_y <= '0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= upd;
      if (upd) begin
        o_accel_x <= next_x;
        o_accel_y <= next_y;
      end
    end
  end

endmodule

// File: tb/tb_accel_reader.sv
// Bench for accel_reader with CLK_DIV=2, POLL_PERIOD=200 and a sensor slave
// model. Build with ACCEL_FILTER_EN defined to exercise the averaging filter.
module tb_accel_reader;

  localparam int CLK_DIV     = 2;
  localparam int POLL_PERIOD = 200;

`ifdef ACCEL_FILTER_EN
  localparam logic [7:0] EXP31_X = 8'h09;
  localparam logic [7:0] EXP31_Y = 8'hF8;
`else
  localparam logic [7:0] EXP31_X = 8'h12;
  localparam logic [7:0] EXP31_Y = 8'hF0;
`endif

  logic       clk = 1'b0;
  logic       arst_n;
  logic       spi_miso = 1'b0;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic [7:0] ax;
  logic [7:0] ay;
  logic       valid;

  always #5 clk = ~clk;

  accel_reader #(
    .CLK_DIV     (CLK_DIV),
    .POLL_PERIOD (POLL_PERIOD)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_spi_miso (spi_miso),
    .o_spi_sclk (sclk),
    .o_spi_mosi (mosi),
    .o_spi_cs_n (cs_n),
    .o_accel_x  (ax),
    .o_accel_y  (ay),
    .o_valid    (valid)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

`ifdef ACCEL_FILTER_EN
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    s = s >>> 1;
    return s[7:0];
  endfunction
`endif

  // Observed SPI transaction
  typedef struct {
    int          nbits;
    logic [31:0] mo;
    int          low;
    int          fall;
    int          nval;
  } txn_t;

  typedef struct {
    logic [7:0] ix;
    logic [7:0] iy;
    logic [7:0] ex;
    logic [7:0] ey;
  } vec_t;

  txn_t       txq[$];
  logic [15:0] sbq[$];
  logic [7:0] sx = 8'h00;
  logic [7:0] sy = 8'h00;
  int         cyc = 0;
  int         n_valid = 0;

  // Slave response: two junk bytes (must be ignored) then X and Y
  function automatic logic slave_bit(input int k);
    logic [31:0] w;
    w = {8'hA5, 8'h5A, sx, sy};
    if (k >= 32) return 1'b0;
    return w[31-k];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Sensor slave, SCLK/MOSI checker, output-stability checker and scoreboard
  logic        p_cs = 1'b1, p_sclk = 1'b0, p_valid = 1'b0, in_txn = 1'b0, low_ok = 1'b0;
  logic        mosi_hi = 1'b0;
  logic [7:0]  px = 8'h00, py = 8'h00, mx = 8'h00, my = 8'h00;
  logic [15:0] rxd = 16'h0, e;
  int          run = 0;
  txn_t        cur;

  initial forever begin
    @(negedge clk);
    if (!arst_n) begin
      in_txn = 1'b0;
      low_ok = 1'b0;
      run    = 0;
      sbq.delete();
      mx = 8'h00;
      my = 8'h00;
      spi_miso = 1'b0;
    end else begin
      if (!p_cs && cs_n && in_txn) begin
        in_txn   = 1'b0;
        cur.nval = n_valid;
        txq.push_back(cur);
        if (cur.nbits == 32 && cur.mo == 32'h0B080000) begin
`ifdef ACCEL_FILTER_EN
          mx = avg8(mx, rxd[15:8]);
          my = avg8(my, rxd[7:0]);
          sbq.push_back({mx, my});
`else
          sbq.push_back(rxd);
`endif
        end
      end
      if (p_cs && !cs_n) begin
        in_txn    = 1'b1;
        low_ok    = 1'b0;
        run       = 0;
        cur.nbits = 0;
        cur.mo    = 32'h0;
        cur.low   = 0;
        cur.fall  = cyc;
        rxd       = 16'h0;
        spi_miso  = slave_bit(0);
      end
      if (in_txn) begin
        cur.low++;
        if (sclk == p_sclk) begin
          run++;
        end else begin
          if (sclk) begin
            if (low_ok) chk("sclk_low_len", run, 2);
            cur.mo  = {cur.mo[30:0], mosi};
            rxd     = {rxd[14:0], spi_miso};
            cur.nbits++;
            mosi_hi = mosi;
          end else begin
            chk("sclk_high_len", run, 2);
            low_ok   = 1'b1;
            spi_miso = slave_bit(cur.nbits);
          end
          run = 1;
        end
        if (sclk && p_sclk) chk("mosi_stable_high", mosi, mosi_hi);
      end
      if (valid) begin
        n_valid++;
        chk("valid_width", p_valid, 1'b0);
        if (sbq.size() == 0) begin
          chk("sb_unexpected_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_x", ax, e[15:8]);
          chk("sb_y", ay, e[7:0]);
        end
      end
      if (ax !== px || ay !== py) chk("out_change_without_valid", valid, 1'b1);
    end
    p_cs    = cs_n;
    p_sclk  = sclk;
    p_valid = valid;
    px      = ax;
    py      = ay;
  end

  task automatic wait_txn(output txn_t t);
    int n = 0;
    while (txq.size() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (txq.size() == 0) begin
      chk("txn_timeout", 0, 1);
      t.nbits = 0; t.mo = 32'h0; t.low = 0; t.fall = 0; t.nval = 0;
    end else begin
      t = txq.pop_front();
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 2000);
    if (!valid) chk({name, "_valid_timeout"}, 0, 1);
  endtask

  task automatic wait_fall();
    int   n = 0;
    logic pc;
    pc = cs_n;
    do begin
      @(negedge clk);
      n++;
      if (pc && !cs_n) break;
      pc = cs_n;
    end while (n < 2000);
    if (n >= 2000) chk("cs_fall_timeout", 0, 1);
  endtask

  task automatic check_init(input string name, input txn_t t);
    chk({name, "_nbits"}, t.nbits, 24);
    chk({name, "_mosi"}, t.mo, 32'h000A2D02);
    chk({name, "_cs_low"}, t.low, 100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  txn_t       t0, t1, t2;
  logic [7:0] hx, hy;
  vec_t       tbl[4];

  initial begin
`ifdef ACCEL_FILTER_EN
    tbl[0] = '{8'h20, 8'hF8, 8'h10, 8'hFC};
    tbl[1] = '{8'h20, 8'h02, 8'h18, 8'hFF};
    tbl[2] = '{8'h00, 8'h00, 8'h0C, 8'hFF};
    tbl[3] = '{8'h7F, 8'h80, 8'h45, 8'hBF};
`else
    tbl[0] = '{8'h7F, 8'h80, 8'h7F, 8'h80};
    tbl[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    tbl[2] = '{8'h55, 8'hAA, 8'h55, 8'hAA};
    tbl[3] = '{8'h01, 8'h81, 8'h01, 8'h81};
`endif

    // Reset state
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_x", ax, 8'h00);
    chk("rst_y", ay, 8'h00);
    chk("rst_valid", valid, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;

    // Init write after release
    wait_txn(t0);
    check_init("init", t0);

    // Periodic reads returning X=0x12, Y=0xF0
    sx = 8'h12;
    sy = 8'hF0;
    wait_txn(t1);
    chk("read_nbits", t1.nbits, 32);
    chk("read_mosi", t1.mo, 32'h0B080000);
    chk("read_cs_low", t1.low, 132);
    wait_txn(t2);
    chk("poll_spacing", t2.fall - t1.fall, 200);
    chk("valid_per_read", t2.nval - t1.nval, 1);
    chk("read_x", ax, EXP31_X);
    chk("read_y", ay, EXP31_Y);

    // Slave data changes in the middle of a read
    wait_fall();
    repeat (20) @(negedge clk);
    hx = ax;
    hy = ay;
    sx = 8'h3C;
    sy = 8'hC3;
    wait_valid("midchg");
    chk("midchg_x_changed", ax != hx, 1'b1);
    chk("midchg_y_changed", ay != hy, 1'b1);
`ifndef ACCEL_FILTER_EN
    chk("midchg_x", ax, 8'h3C);
    chk("midchg_y", ay, 8'hC3);
`endif

    // Reset pulsed during byte 3 of a read
    wait_fall();
    repeat (75) @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1'b1);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_mosi", mosi, 1'b0);
    chk("abort_x", ax, 8'h00);
    chk("abort_y", ay, 8'h00);
    chk("abort_valid", valid, 1'b0);
    repeat (3) @(negedge clk);
    txq.delete();
    arst_n = 1'b1;
    wait_txn(t0);
    check_init("reinit", t0);

    // Table of samples following a fresh reset
    for (int i = 0; i < 4; i++) begin
      sx = tbl[i].ix;
      sy = tbl[i].iy;
      wait_valid("tbl");
      chk($sformatf("tbl%0d_x", i), ax, tbl[i].ex);
      chk($sformatf("tbl%0d_y", i), ay, tbl[i].ey);
    end
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
